garage_input_conditioner: RTL
=============================

// Module: garage_input_conditioner
// PURPOSE
//   Front-end stage feeding the garage door controller FSM.
//   - Synchronises and debounces the raw push-button and both limit switches.
//   - Turns each press into a single-cycle Activate pulse, then applies a lockout.
//   - Blocks contradictory limit-switch readings (both asserted) before they reach the FSM.
// PARAMETERS
//   SYNC_STAGES    2      synchroniser flops per raw input (>=2)
//   DB_CYCLES      16     consecutive cycles a synced input must differ from its debounced value to be accepted (>=2)
//   LOCKOUT_CYCLES 64     cycles after an Activate pulse during which further presses are ignored (>=1)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   btn_raw    in   1  asynchronous push-button, 1 = pressed, may bounce
//   up_sw_raw  in   1  asynchronous up-limit switch, 1 = door fully open
//   dn_sw_raw  in   1  asynchronous down-limit switch, 1 = door fully closed
//   Activate   out  1  one-cycle pulse per accepted press, to FSM Activate
//   Up_Max     out  1  debounced up-limit, to FSM Up_Max
//   DN_Max     out  1  debounced down-limit, to FSM DN_Max
//   sw_fault   out  1  1 while both debounced limits are high
// BEHAVIOUR
//   Clocking and reset
//   - One clock, clk; reset is synchronous and active-high (rst).
//   - rst=1 at a rising edge clears all state: sync flops, debounced values, debounce counters,
//     edge register and lockout counter.
//   - Outputs are 0 in the cycle after any reset edge: Activate=0, Up_Max=0, DN_Max=0, sw_fault=0.
//   - Reset mid-debounce or mid-lockout discards that progress.
//   Synchroniser
//   - One SYNC_STAGES-deep flop chain per raw input, all reset to 0.
//   Debounce (independent per channel; db = debounced value, cnt = counter)
//   - sync==db: cnt<=0.
//   - sync!=db and cnt<DB_CYCLES-1: cnt<=cnt+1.
//   - sync!=db and cnt==DB_CYCLES-1: db<=sync, cnt<=0.
//   - Any glitch back to db before acceptance clears cnt; no partial credit is kept.
//   - Latency: a raw level held steady appears on db at the (SYNC_STAGES+DB_CYCLES)-th rising edge,
//     counting the first edge that samples the new value as edge 1.
//   - Counter width is $clog2(DB_CYCLES). It never wraps: it saturates by acceptance.
//   Activate generation (states IDLE, LOCK)
//   - IDLE: a rising edge of btn_db (btn_db=1, previous btn_db=0) with sw_fault=0 drives
//     Activate=1 for exactly one cycle, loads lock_cnt=LOCKOUT_CYCLES-1 and moves to LOCK.
//   - LOCK: Activate=0; lock_cnt decrements each cycle; at lock_cnt==0 the next state is IDLE.
//   - A press whose rising edge falls in LOCK is dropped, not queued.
//   - A button held down yields one pulse only; a new pulse needs release and re-press.
//   - A rising edge while sw_fault=1 produces no pulse and does not enter LOCK.
//   - Activate is registered: it is high in the cycle after the edge where btn_db rises.
//   Limit outputs
//   - sw_fault = up_db & dn_db.
//   - Up_Max = up_db & ~sw_fault; DN_Max = dn_db & ~sw_fault. Both are 0 during a fault.
//   - sw_fault is non-sticky and clears as soon as either debounced limit drops.
//   - No added latency beyond debounce: outputs come from db registers through gates only.
//   Simultaneous events
//   - A limit change and a button edge on the same cycle are processed independently.
//   - The fault check uses the same-cycle debounced limit values.
// TESTING
//   - Reset: rst=1 for 3 cycles with all raw inputs=1 -> all outputs 0 during reset and at the first
//     post-reset cycle; dn_sw_raw=1 held -> DN_Max=1 at edge 18 (defaults).
//   - Bounce rejection: btn_raw toggles every 5 cycles for 100 cycles, then 0 -> Activate never asserts.
//   - Clean press: btn_raw=1 held for 200 cycles -> exactly one Activate pulse, 1 cycle wide,
//     19 edges after the first sampling edge.
//   - Lockout: two clean presses with pulses 40 cycles apart -> second dropped; repeat with a 70-cycle
//     gap -> two pulses.
//   - Fault: up_sw_raw=1 and dn_sw_raw=1 stable -> sw_fault=1, Up_Max=0, DN_Max=0, press gives no
//     Activate; release up_sw_raw -> sw_fault=0 and DN_Max=1 after 18 edges.
//   - Reset mid-debounce: btn_raw=1 for 10 cycles, pulse rst, hold btn_raw=1 -> pulse only after a
//     full 18+1 edges following reset release.

Source files
------------

// File: rtl/garage_input_conditioner.sv
// garage_input_conditioner: synchronise/debounce button and limit switches, emit one Activate pulse per press with lockout
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   btn_raw, up_sw_raw, dn_sw_raw   asynchronous raw button / up-limit / down-limit
//   Activate                        one-cycle pulse per accepted press
//   Up_Max, DN_Max                  debounced limits, both forced low during a fault
//   sw_fault                        high while both debounced limits are high
module garage_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic up_sw_raw,
  input  logic dn_sw_raw,
  output logic Activate,
  output logic Up_Max,
  output logic DN_Max,
  output logic sw_fault
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int LW = LOCKOUT_CYCLES > 1 ? $clog2(LOCKOUT_CYCLES) : 1;
  typedef enum logic {IDLE, LOCK} state_t;
  logic [2:0] raw, db;
  assign raw = {dn_sw_raw, up_sw_raw, btn_raw};
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic db_q, db_d, diff, acc;
    always_comb begin
      diff  = sync_q[SYNC_STAGES-1] ^ db_q;
      acc   = diff && cnt_q == CW'(DB_CYCLES - 1);
      cnt_d = (diff && !acc) ? cnt_q + 1'b1 : '0;
      db_d  = db_q ^ acc;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        db_q   <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        cnt_q  <= cnt_d;
        db_q   <= db_d;
      end
    end
    assign db[g] = db_q;
  end
  state_t state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic btn_prev_q, act_q, act_d, fire;
  assign sw_fault = db[1] & db[2];
  assign Up_Max   = db[1] & ~sw_fault;
  assign DN_Max   = db[2] & ~sw_fault;
  assign Activate = act_q;
  always_comb begin
    fire    = state_q == IDLE && db[0] && !btn_prev_q && !sw_fault;
    act_d   = fire;
    state_d = fire ? LOCK : (state_q == LOCK && lock_q == '0) ? IDLE : state_q;
    lock_d  = fire ? LW'(LOCKOUT_CYCLES - 1) : (state_q == LOCK && lock_q != '0) ? lock_q - 1'b1 : lock_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      btn_prev_q <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      btn_prev_q <= db[0];
      act_q      <= act_d;
    end
  end
endmodule
